// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state and entry type for the fetch front end
package fetch_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with registered storage; flush overrides push/pop
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);
    assign do_push   = push && !flush && !full;
    assign do_pop    = pop && !flush && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, imem req/ack, prefetch FIFO, redirect/flush
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed saturating counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_FREE = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_ONE    = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] kill_addr, kill_addr_nxt;
    logic              push, pop, full, empty;
    logic [CNT_W-1:0]  count;
    entry_t            wr_entry, head;

    assign imem_req    = (state == FETCH) || (state == KILL);
    assign imem_addr   = (state == KILL) ? kill_addr : fetch_pc;
    assign instr_valid = !empty;
    assign instr_pc    = head.pc;
    assign instr_data  = head.instr;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign push        = (state == FETCH) && imem_ack && !redirect_valid;
    assign wr_entry    = '{pc: fetch_pc, instr: imem_rdata};

    fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            kill_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            kill_addr <= kill_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        kill_addr_nxt = kill_addr;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            // An open, unacked request must still complete; remember its address while killing it.
            if (state == KILL) begin
                state_nxt = imem_ack ? FETCH : KILL;
            end else if (imem_req && !imem_ack) begin
                state_nxt     = KILL;
                kill_addr_nxt = fetch_pc;
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                IDLE:  if (!full) state_nxt = FETCH;
                FETCH: if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + PC_ONE;
                    state_nxt    = (pop || count < LAST_FREE) ? FETCH : IDLE;
                end
                KILL:  if (imem_ack) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        dropped;
    logic [16:0] flushed_sum;

    assign dropped     = imem_ack && ((state == KILL) || (state == FETCH && redirect_valid));
    assign flushed_sum = {1'b0, perf_flushed} + 17'(redirect_valid ? count : '0) + 17'(dropped);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
            perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven and scoreboard checks for fetch_stage
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    int tests = 0;
    int errors = 0;

    fetch_entry_t q[$];
    logic         killing = 1'b0;
    logic [15:0]  exp_pc = '0;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_req;
        logic        exp_valid;
        logic        chk_addr;
        logic [15:0] exp_addr;
    } vec_t;
    vec_t vecs[$];

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ack, input logic rdy, input logic redir, input logic [15:0] rpc,
                                input logic req, input logic valid, input logic chk, input logic [15:0] addr);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.exp_req = req; v.exp_valid = valid; v.chk_addr = chk; v.exp_addr = addr;
        return v;
    endfunction

    // Drive one cycle, update the scoreboard for what the edge will do, then sample after the edge.
    task automatic cycle(input logic ack, input logic rdy, input logic redir, input logic [15:0] rpc);
        fetch_entry_t e;
        imem_ack       = ack && imem_req;
        imem_rdata     = imem_addr ^ 16'h5A3C;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (imem_req && !killing) check("imem_addr", imem_addr, exp_pc);
        if (redir) begin
            q.delete();
            killing = imem_req && !imem_ack;
            exp_pc  = rpc;
        end else begin
            if (instr_valid && rdy) begin
                if (q.size() == 0) begin
                    check("pop_on_empty_model", 16'(instr_valid), 16'd0);
                end else begin
                    e = q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr_data", instr_data, e.instr);
                end
            end
            if (imem_ack) begin
                if (killing) begin
                    killing = 1'b0;
                end else begin
                    q.push_back('{pc: exp_pc, instr: imem_rdata});
                    exp_pc = exp_pc + 16'd1;
                end
            end
        end
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        check("instr_valid_vs_model", 16'(instr_valid), 16'(q.size() != 0));
    endtask

    initial begin
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 1, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 1, 16'h0001));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 1, 16'h0002));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 1, 16'h0003));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 1, 16'h0004));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 1, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0005));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0006));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0007));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0008));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 1, 0, 1, 16'h0040));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 1, 16'h0040));

        #12;
        check("rst imem_req", 16'(imem_req), 16'd0);
        check("rst imem_addr", imem_addr, 16'h0000);
        check("rst instr_valid", 16'(instr_valid), 16'd0);
        check("rst instr_data", instr_data, 16'h0000);
        check("rst instr_pc", instr_pc, 16'h0000);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].ack, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            check($sformatf("v%0d imem_req", i), 16'(imem_req), 16'(vecs[i].exp_req));
            check($sformatf("v%0d instr_valid", i), 16'(instr_valid), 16'(vecs[i].exp_valid));
            if (vecs[i].chk_addr) check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
        end

        // PC wrap, entered through a redirect whose ack lands the same cycle (data dropped)
        cycle(1, 1, 1, 16'hFFFE);
        check("wrap redirect drop valid", 16'(instr_valid), 16'd0);
        check("wrap start addr", imem_addr, 16'hFFFE);
        cycle(1, 1, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        check("wrap next addr", imem_addr, 16'h0000);
        check("wrap head pc", instr_pc, 16'hFFFF);
        cycle(0, 1, 0, 16'h0000);

        // Redirect with a request open at 0x0005, ack three cycles later
        cycle(1, 1, 1, 16'h0005);
        check("kill setup addr", imem_addr, 16'h0005);
        cycle(0, 1, 1, 16'h0100);
        for (int k = 0; k < 2; k++) begin
            check("kill held req", 16'(imem_req), 16'd1);
            check("kill held addr", imem_addr, 16'h0005);
            cycle(0, 1, 0, 16'h0000);
        end
        check("kill held addr last", imem_addr, 16'h0005);
        cycle(1, 1, 0, 16'h0000);
        check("kill no push", 16'(instr_valid), 16'd0);
        check("kill restart addr", imem_addr, 16'h0100);
        cycle(0, 1, 0, 16'h0000);

        // Reset mid-request drops imem_req without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check("async rst imem_req", 16'(imem_req), 16'd0);
        check("async rst imem_addr", imem_addr, 16'h0000);
        q.delete();
        killing = 1'b0;
        exp_pc  = 16'h0000;
        @(negedge clock);
        reset = 1'b1;

        // 5 pushes, 3 pops, then redirect with 2 buffered and 1 in flight
        cycle(0, 0, 0, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        check("pre-flush valid", 16'(instr_valid), 16'd1);
        cycle(0, 0, 1, 16'h0200);
        check("flush valid", 16'(instr_valid), 16'd0);
        cycle(1, 0, 0, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 16'd5);
        check("perf_flushed", perf_flushed, 16'd3);
`endif
        check("post-kill addr", imem_addr, 16'h0200);
        cycle(1, 1, 0, 16'h0000);
        cycle(0, 1, 0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
